// File: rtl/cmac_lbus_pkg.sv
// Shared types and helpers for the AXI4-Stream to CMAC LBUS TX path.
// Beats are sized for the widest (4-segment) build; narrower builds zero-fill.
package cmac_lbus_pkg;

   localparam int SEG_BYTES  = 16;
   localparam int SEG_W      = 128;
   localparam int MTY_W      = 4;
   localparam int MAX_SEG    = 4;
   localparam int MAX_DATA_W = SEG_W * MAX_SEG;
   localparam int MAX_KEEP_W = SEG_BYTES * MAX_SEG;

   typedef struct packed {
      logic [MAX_DATA_W-1:0] data;
      logic [MAX_KEEP_W-1:0] keep;
      logic                  last;
      logic                  err;
   } lbus_beat_t;

   // Number of contiguous ones in keep starting at bit 0.
   function automatic logic [6:0] keep_len(input logic [MAX_KEEP_W-1:0] keep);
      logic [6:0] n;
      logic       run;
      n   = '0;
      run = 1'b1;
      for (int b = 0; b < MAX_KEEP_W; b++) begin
         if (run && keep[b]) n = n + 7'd1;
         else                run = 1'b0;
      end
      return n;
   endfunction

   // True when keep has the shape 2^k-1 (including all zero).
   function automatic logic keep_contig(input logic [MAX_KEEP_W-1:0] keep);
      return (keep & (keep + MAX_KEEP_W'(1))) == '0;
   endfunction

endpackage

// File: rtl/cmac_axi2lbus_skid.sv
// Two-entry skid buffer between the AXI slave side and the LBUS issue stage.
// Ready is registered from the next-state occupancy so it never depends on pop.
module cmac_axi2lbus_skid
   import cmac_lbus_pkg::*;
#(
   parameter int W = $bits(lbus_beat_t)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] in_i,
   input  logic         push_i,
   output logic         ready_o,
   output logic [W-1:0] head_o,
   output logic         valid_o,
   input  logic         pop_i
);

   logic [1:0]   cnt_q, cnt_d;
   logic [W-1:0] e0_q, e0_d;
   logic [W-1:0] e1_q, e1_d;
   logic         rdy_q, rdy_d;
   logic         push, pop;

   assign push    = push_i & rdy_q;
   assign pop     = pop_i & (cnt_q != 2'd0);
   assign ready_o = rdy_q;
   assign valid_o = (cnt_q != 2'd0);
   assign head_o  = e0_q;

   // Next-state occupancy and entry shuffling for push/pop combinations
   always_comb begin
      cnt_d = cnt_q;
      e0_d  = e0_q;
      e1_d  = e1_q;
      unique case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) e0_d = in_i;
            else               e1_d = in_i;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               e0_d = in_i;
            end else begin
               e0_d = e1_q;
               e1_d = in_i;
            end
         end
         default: ;
      endcase
      rdy_d = (cnt_d != 2'd2);
   end

   // Buffer state; reset flushes both entries and holds ready low
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         e0_q  <= '0;
         e1_q  <= '0;
         rdy_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         rdy_q <= rdy_d;
      end
   end

endmodule

// File: rtl/cmac_axi2lbus_seg.sv
// AXI4-Stream to CMAC LBUS TX converter with skid buffer, error marking,
// sticky CMAC status flags and packet/violation counters.
module cmac_axi2lbus_seg
   import cmac_lbus_pkg::*;
#(
   parameter  int SEGMENTS = 4,
   parameter  int CNT_W    = 32,
   localparam int DATA_W   = SEG_W * SEGMENTS,
   localparam int KEEP_W   = SEG_BYTES * SEGMENTS
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  lbus_rst_i,
   input  logic [DATA_W-1:0]     s_tdata,
   input  logic [KEEP_W-1:0]     s_tkeep,
   input  logic                  s_tuser,
   input  logic                  s_tlast,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   output logic [DATA_W-1:0]     tx_datain,
   output logic [SEGMENTS-1:0]   tx_enain,
   output logic [SEGMENTS-1:0]   tx_sopin,
   output logic [SEGMENTS-1:0]   tx_eopin,
   output logic [SEGMENTS-1:0]   tx_errin,
   output logic [4*SEGMENTS-1:0] tx_mtyin,
   input  logic                  tx_rdyout,
   input  logic                  tx_ovfout,
   input  logic                  tx_unfout,
   input  logic                  clr_stats,
   output logic [CNT_W-1:0]      pkt_cnt,
   output logic [CNT_W-1:0]      err_pkt_cnt,
   output logic [CNT_W-1:0]      proto_err_cnt,
   output logic                  ovf_flag,
   output logic                  unf_flag
);

   logic rst;
   assign rst = RST | lbus_rst_i;

   lbus_beat_t in_beat, head;
   logic       head_vld, pop;
   logic       v_shape, v_part, v_zero;
   logic [1:0] proto_inc;
   logic [MAX_KEEP_W-1:0] keep_x;

   // Accept side: pack the beat and classify tkeep violations
   always_comb begin
      keep_x                 = '0;
      keep_x[KEEP_W-1:0]     = s_tkeep;
      v_shape                = ~keep_contig(keep_x);
      v_part                 = ~s_tlast & ~(&s_tkeep);
      v_zero                 = ~(|s_tkeep);
      in_beat                = '0;
      in_beat.data[DATA_W-1:0] = s_tdata;
      in_beat.keep           = keep_x;
      in_beat.last           = s_tlast;
      in_beat.err            = s_tuser | v_shape | v_part | v_zero;
      proto_inc              = 2'd0;
      if (s_tvalid & s_tready)
         proto_inc = {1'b0, v_shape} + {1'b0, v_part} + {1'b0, v_zero};
   end

   cmac_axi2lbus_skid #(
      .W($bits(lbus_beat_t))
   ) u_skid (
      .clk_i   (CLK),
      .rst_i   (rst),
      .in_i    (in_beat),
      .push_i  (s_tvalid),
      .ready_o (s_tready),
      .head_o  (head),
      .valid_o (head_vld),
      .pop_i   (pop)
   );

   assign pop = tx_rdyout & head_vld;

   logic [DATA_W-1:0]     data_q, data_d;
   logic [SEGMENTS-1:0]   en_q, en_d, sop_q, sop_d;
   logic [SEGMENTS-1:0]   eop_q, eop_d, err_q, err_d;
   logic [4*SEGMENTS-1:0] mty_q, mty_d;
   logic                  in_pkt_q, in_pkt_d;
   logic                  pkt_err_q, pkt_err_d;
   logic [6:0]            len_raw, len, len_m1, len_neg;
   logic [1:0]            fseg;
   logic                  cur_err;

   // Segment mapper: head entry onto LBUS lanes, idle when nothing issues
   always_comb begin
      len_raw   = keep_len(head.keep);
      len       = (len_raw == 7'd0) ? 7'd1 : len_raw;
      len_m1    = len - 7'd1;
      len_neg   = 7'd0 - len;
      fseg      = len_m1[5:4];
      cur_err   = pkt_err_q | head.err;
      data_d    = data_q;
      en_d      = '0;
      sop_d     = '0;
      eop_d     = '0;
      err_d     = '0;
      mty_d     = '0;
      in_pkt_d  = in_pkt_q;
      pkt_err_d = pkt_err_q;
      if (pop) begin
         for (int i = 0; i < SEGMENTS; i++) begin
            for (int j = 0; j < SEG_BYTES; j++)
               data_d[SEG_W*i + SEG_W-1 - 8*j -: 8] =
                  head.data[8*(SEG_BYTES*i + j) +: 8];
            if (head.last) begin
               en_d[i] = (7'(SEG_BYTES*i) < len);
               if (fseg == 2'(i)) begin
                  eop_d[i]                = 1'b1;
                  err_d[i]                = cur_err;
                  mty_d[MTY_W*i +: MTY_W] = len_neg[3:0];
               end
            end else begin
               en_d[i] = 1'b1;
            end
         end
         sop_d[0]  = ~in_pkt_q;
         in_pkt_d  = ~head.last;
         pkt_err_d = head.last ? 1'b0 : cur_err;
      end
   end

   // LBUS output register and packet state
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         data_q    <= '0;
         en_q      <= '0;
         sop_q     <= '0;
         eop_q     <= '0;
         err_q     <= '0;
         mty_q     <= '0;
         in_pkt_q  <= 1'b0;
         pkt_err_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         en_q      <= en_d;
         sop_q     <= sop_d;
         eop_q     <= eop_d;
         err_q     <= err_d;
         mty_q     <= mty_d;
         in_pkt_q  <= in_pkt_d;
         pkt_err_q <= pkt_err_d;
      end
   end

   assign tx_datain = data_q;
   assign tx_enain  = en_q;
   assign tx_sopin  = sop_q;
   assign tx_eopin  = eop_q;
   assign tx_errin  = err_q;
   assign tx_mtyin  = mty_q;

   logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] proto_cnt_q, proto_cnt_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             pkt_inc, err_inc;

   // Statistics next state: clear first, then this cycle's increment
   always_comb begin
      pkt_inc     = pop & head.last;
      err_inc     = pkt_inc & cur_err;
      pkt_cnt_d   = (clr_stats ? '0 : pkt_cnt_q) + CNT_W'(pkt_inc);
      err_cnt_d   = (clr_stats ? '0 : err_cnt_q) + CNT_W'(err_inc);
      proto_cnt_d = (clr_stats ? '0 : proto_cnt_q) + CNT_W'(proto_inc);
      ovf_d       = tx_ovfout | (ovf_q & ~clr_stats);
      unf_d       = tx_unfout | (unf_q & ~clr_stats);
   end

   // Counters and sticky flags
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         pkt_cnt_q   <= '0;
         err_cnt_q   <= '0;
         proto_cnt_q <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         pkt_cnt_q   <= pkt_cnt_d;
         err_cnt_q   <= err_cnt_d;
         proto_cnt_q <= proto_cnt_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   assign pkt_cnt       = pkt_cnt_q;
   assign err_pkt_cnt   = err_cnt_q;
   assign proto_err_cnt = proto_cnt_q;
   assign ovf_flag      = ovf_q;
   assign unf_flag      = unf_q;

endmodule

// File: tb/tb_cmac_axi2lbus_seg.sv
// Bench for cmac_axi2lbus_seg: directed steps plus randomized packets
// checked against a packet-level LBUS reference model.
module tb_cmac_axi2lbus_seg;

   localparam int SEGMENTS = 4;
   localparam int CNT_W    = 32;

   logic          CLK = 1'b0;
   logic          RST, lbus_rst_i;
   logic [511:0]  s_tdata;
   logic [63:0]   s_tkeep;
   logic          s_tuser, s_tlast, s_tvalid, s_tready;
   logic [511:0]  tx_datain;
   logic [3:0]    tx_enain, tx_sopin, tx_eopin, tx_errin;
   logic [15:0]   tx_mtyin;
   logic          tx_rdyout, tx_ovfout, tx_unfout, clr_stats;
   logic [31:0]   pkt_cnt, err_pkt_cnt, proto_err_cnt;
   logic          ovf_flag, unf_flag;

   cmac_axi2lbus_seg #(.SEGMENTS(SEGMENTS), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .lbus_rst_i(lbus_rst_i),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
      .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .tx_datain(tx_datain), .tx_enain(tx_enain), .tx_sopin(tx_sopin),
      .tx_eopin(tx_eopin), .tx_errin(tx_errin), .tx_mtyin(tx_mtyin),
      .tx_rdyout(tx_rdyout), .tx_ovfout(tx_ovfout), .tx_unfout(tx_unfout),
      .clr_stats(clr_stats), .pkt_cnt(pkt_cnt), .err_pkt_cnt(err_pkt_cnt),
      .proto_err_cnt(proto_err_cnt), .ovf_flag(ovf_flag), .unf_flag(unf_flag)
   );

   initial forever #5 CLK = ~CLK;

   typedef struct {
      logic [511:0] d;
      logic [3:0]   en, sop, eop, err;
      logic [15:0]  mty;
   } exp_t;

   exp_t expq[$];
   int   tests = 0, fails = 0;
   int   m_pkt = 0, m_err = 0, m_proto = 0;
   int   occ = 0;
   bit   issued = 0, iss_w = 0, rst_win = 1, tog_en = 0;
   int   ph = 0;

   task automatic check(input string tag, input logic [511:0] obs,
                        input logic [511:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic int lead_ones(input logic [63:0] k);
      int n = 0;
      while (n < 64 && k[n]) n++;
      return n;
   endfunction

   function automatic logic [63:0] mask(input int n);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < n && i < 64; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic bit contig(input logic [63:0] k);
      return k == mask(lead_ones(k));
   endfunction

   function automatic logic [511:0] map_data(input logic [511:0] d);
      logic [511:0] r;
      r = '0;
      for (int k = 0; k < 64; k++)
         r[128*(k/16) + 127 - 8*(k%16) -: 8] = d[8*k +: 8];
      return r;
   endfunction

   // Buffer occupancy seen from the outside: accepted minus issued beats
   always @(posedge CLK) begin
      if (RST || lbus_rst_i) begin
         occ = 0; issued = 0; rst_win = 1;
      end else begin
         iss_w   = tx_rdyout && occ > 0;
         occ     = occ + int'(s_tvalid && s_tready) - int'(iss_w);
         issued  = iss_w;
         rst_win = 0;
      end
   end

   // LBUS monitor against the expected-beat queue
   always @(negedge CLK) begin
      exp_t e;
      if (!(RST || lbus_rst_i) && !rst_win) begin
         check("ready", s_tready, occ < 2);
         check("issue", tx_enain != 0, issued);
         if (tx_enain != 0) begin
            if (expq.size() == 0) begin
               check("unexpected_beat", 1'b1, 1'b0);
            end else begin
               e = expq.pop_front();
               check("beat_ctl",
                     {tx_enain, tx_sopin, tx_eopin, tx_errin, tx_mtyin},
                     {e.en, e.sop, e.eop, e.err, e.mty});
               check("beat_data", tx_datain, e.d);
            end
         end else begin
            check("idle_ctl", {tx_sopin, tx_eopin, tx_errin, tx_mtyin}, 0);
         end
      end
   end

   // CMAC ready pattern: 3 cycles high, 2 low
   initial forever begin
      @(posedge CLK); #1;
      if (tog_en) begin
         tx_rdyout = (ph < 3);
         ph = (ph + 1) % 5;
      end
   end

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic drive_beat(input logic [511:0] d, input logic [63:0] k,
                             input logic l, input logic u, input logic clr);
      int  guard = 0;
      bit  acc = 0;
      s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u;
      s_tvalid = 1'b1; clr_stats = clr;
      while (!acc && guard < 2000) begin
         @(negedge CLK); acc = s_tready;
         tick();
         guard++;
      end
      if (!acc) check("drive_timeout", 1'b1, 1'b0);
      s_tvalid = 1'b0; clr_stats = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (expq.size() != 0 && g < 3000) begin tick(); g++; end
      check("drain", expq.size(), 0);
   endtask

   task automatic send_pkt(input int nbytes, input int user_beat,
                           input int bad_beat, input logic [63:0] bad_keep,
                           input int nsend, input bit clr_first,
                           input bit gaps, input bit track);
      int nb, ns, v, L, f;
      bit perr;
      logic [511:0] t;
      logic [63:0]  kk;
      logic [511:0] d[$];
      logic [63:0]  k[$];
      bit           u[$];
      exp_t         e;
      nb   = (nbytes + 63) / 64;
      ns   = (nsend < 0 || nsend > nb) ? nb : nsend;
      perr = 0;
      for (int b = 0; b < nb; b++) begin
         for (int w = 0; w < 16; w++) t[32*w +: 32] = $urandom;
         d.push_back(t);
         kk = (b < nb-1) ? '1 : mask(nbytes - 64*(nb-1));
         if (b == bad_beat) kk = bad_keep;
         k.push_back(kk);
         u.push_back(b == user_beat);
      end
      if (track) begin
         if (clr_first) begin m_pkt = 0; m_err = 0; m_proto = 0; end
         for (int b = 0; b < ns; b++) begin
            v = 0;
            if (!contig(k[b])) v++;
            if (b != nb-1 && k[b] != '1) v++;
            if (k[b] == 0) v++;
            m_proto += v;
            perr |= u[b] || (v != 0);
         end
         for (int b = 0; b < ns; b++) begin
            e.d = map_data(d[b]);
            e.sop = (b == 0) ? 4'b0001 : 4'b0000;
            e.en = 0; e.eop = 0; e.err = 0; e.mty = 0;
            if (b == nb-1) begin
               L = lead_ones(k[b]);
               if (L == 0) L = 1;
               f = (L - 1) / 16;
               for (int i = 0; i < 4; i++) if (16*i < L) e.en[i] = 1'b1;
               e.eop[f] = 1'b1;
               e.err[f] = perr;
               e.mty[4*f +: 4] = 4'(16*(f+1) - L);
               m_pkt++;
               if (perr) m_err++;
            end else begin
               e.en = 4'hF;
            end
            expq.push_back(e);
         end
      end
      for (int b = 0; b < ns; b++) begin
         drive_beat(d[b], k[b], b == nb-1, u[b], clr_first && b == 0);
         if (gaps) repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   task automatic check_cnts(input string tag);
      check(tag, {pkt_cnt, err_pkt_cnt, proto_err_cnt},
            {32'(m_pkt), 32'(m_err), 32'(m_proto)});
   endtask

   initial begin
      int nbeats, n, ub, bb;
      logic [63:0] bk;
      RST = 1; lbus_rst_i = 0;
      s_tdata = '0; s_tkeep = '0; s_tuser = 0; s_tlast = 0; s_tvalid = 0;
      tx_rdyout = 0; tx_ovfout = 0; tx_unfout = 0; clr_stats = 0;
      repeat (3) tick();
      check("rst_tready", s_tready, 1'b0);
      check("rst_lbus", {tx_datain, tx_enain, tx_sopin, tx_eopin,
                         tx_errin, tx_mtyin}, 0);
      check("rst_stats", {pkt_cnt, err_pkt_cnt, proto_err_cnt,
                          ovf_flag, unf_flag}, 0);
      RST = 0;
      tick();
      check("ready_after_rst", s_tready, 1'b1);
      tx_rdyout = 1;

      // 64-byte single-beat packet, two-cycle latency
      send_pkt(64, -1, -1, '0, -1, 0, 0, 1);
      tick();
      check("p64_en", tx_enain, 4'hF);
      check("p64_ctl", {tx_sopin, tx_eopin, tx_errin, tx_mtyin},
            {4'b0001, 4'b1000, 4'b0000, 16'h0});
      check("p64_pkt_cnt", pkt_cnt, 32'd1);

      // 65-byte packet
      send_pkt(65, -1, -1, '0, -1, 0, 0, 1);
      drain();
      check_cnts("p65_cnts");

      // non-contiguous keep on the last beat
      send_pkt(20, -1, 0, 64'h0F0F, -1, 0, 0, 1);
      drain();
      check_cnts("keep0f0f_cnts");

      // tuser on the first beat of a 3-beat packet
      send_pkt(150, 0, -1, '0, -1, 0, 0, 1);
      drain();
      check_cnts("tuser_cnts");

      // randomized traffic with toggling CMAC ready
      tog_en = 1;
      nbeats = 0;
      while (nbeats < 100) begin
         n  = $urandom_range(1, 256);
         ub = ($urandom_range(0, 7) == 0) ? $urandom_range(0, (n+63)/64 - 1) : -1;
         bb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, (n+63)/64 - 1) : -1;
         case ($urandom_range(0, 3))
            0:       bk = '0;
            1:       bk = {$urandom, $urandom};
            2:       bk = mask($urandom_range(1, 63));
            default: bk = '1;
         endcase
         send_pkt(n, ub, bb, bk, -1, 0, 1, 1);
         nbeats += (n + 63) / 64;
      end
      drain();
      tog_en = 0;
      tick();
      tx_rdyout = 1;
      check_cnts("random_cnts");

      // violation on a non-last beat together with clr_stats
      send_pkt(100, -1, 0, 64'h0000_0000_0000_FFFF, -1, 1, 0, 1);
      drain();
      check("clr_viol_proto", proto_err_cnt, 32'd1);
      check_cnts("clr_viol_cnts");

      // RST after a partially sent packet
      send_pkt(192, -1, -1, '0, 2, 0, 0, 1);
      drain();
      RST = 1;
      tick();
      m_pkt = 0; m_err = 0; m_proto = 0;
      check_cnts("rst_mid_cnts");
      RST = 0;
      tick();
      send_pkt(64, -1, -1, '0, -1, 0, 0, 1);
      drain();
      check_cnts("after_rst_cnts");

      // lbus reset flushes a full buffer
      tx_rdyout = 0;
      send_pkt(192, -1, -1, '0, 2, 0, 0, 0);
      check("full_tready", s_tready, 1'b0);
      lbus_rst_i = 1;
      tick();
      check("flush_rst", {s_tready, tx_enain}, 0);
      m_pkt = 0; m_err = 0; m_proto = 0;
      lbus_rst_i = 0;
      tick();
      tx_rdyout = 1;
      send_pkt(130, -1, -1, '0, -1, 0, 0, 1);
      drain();
      check_cnts("after_flush_cnts");

      // sticky flags
      tx_ovfout = 1;
      tick();
      tx_ovfout = 0;
      check("ovf_set", {ovf_flag, unf_flag}, 2'b10);
      repeat (3) tick();
      check("ovf_hold", {ovf_flag, unf_flag}, 2'b10);
      tx_unfout = 1; clr_stats = 1;
      tick();
      tx_unfout = 0; clr_stats = 0;
      check("clr_vs_pulse", {ovf_flag, unf_flag}, 2'b01);
      check("clr_counters", {pkt_cnt, err_pkt_cnt, proto_err_cnt}, 0);
      clr_stats = 1;
      tick();
      clr_stats = 0;
      check("clr_unf", {ovf_flag, unf_flag}, 2'b00);

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
